// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
//   N      : number of requesters (power of two)
//   IDX_W  : width of a requester index, log2(N)
//   state_t: arbiter FSM states
package arb_pkg;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   req      in  [N-1:0]     request vector
//   ptr      in  [IDX_W-1:0] position holding highest priority
//   pick     out [N-1:0]     one-hot winner, zero when no request
//   pick_idx out [IDX_W-1:0] binary index of the winner, zero when no request
//   any      out             at least one request present
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [2*N-1:0]   req_dbl;
  logic [2*N-1:0]   pick_dbl;
  logic [N-1:0]     req_rot;
  logic [N-1:0]     rot_pick;
  logic [IDX_W-1:0] rot_idx;
  logic             found;

  always_comb begin
    // Rotate right so position ptr lands on bit 0.
    req_dbl  = {req, req} >> ptr;
    req_rot  = req_dbl[N-1:0];

    // Fixed priority from the LSB on the rotated vector.
    rot_pick = '0;
    rot_idx  = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_rot[i] && !found) begin
        rot_pick[i] = 1'b1;
        rot_idx     = IDX_W'(i);
        found       = 1'b1;
      end
    end

    // Rotate the winner back into requester positions.
    pick_dbl = {rot_pick, rot_pick} << ptr;
    pick     = pick_dbl[2*N-1:N];
    // Index addition wraps mod N because the width is exactly log2(N).
    pick_idx = found ? (rot_idx + ptr) : '0;
    any      = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with a held, registered grant.
// A grant persists until its owner pulses release_grant; on release the
// priority pointer moves to just past the owner and the next winner (if any)
// is granted on the same edge.
// Ports:
//   clk           in               rising-edge clock
//   rst           in               asynchronous active-high reset
//   req           in  [N-1:0]      request vector
//   release_grant in               owner's one-cycle release pulse; ignored
//                                  while no grant is held (`release` is a
//                                  reserved word, hence the longer name)
//   grant         out [N-1:0]      registered one-hot grant, zero when idle
//   grant_valid   out              a grant is held
//   grant_idx     out [IDX_W-1:0]  index of the granted requester, 0 when idle
module rr_arbiter_8
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             release_grant,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_sel;
  logic [N-1:0]     pick;
  logic [IDX_W-1:0] pick_idx;
  logic             any;
  logic             releasing;

  assign releasing = (state == BUSY) && release_grant;

  // On release the pick already uses the advanced pointer so the hand-off
  // completes in the same cycle; the releasing owner ends up lowest priority.
  assign ptr_sel = releasing ? (grant_idx + 1'b1) : ptr;

  rr_pick u_pick (
    .req      (req),
    .ptr      (ptr_sel),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            grant       <= pick;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (release_grant) begin
            ptr <= ptr_sel;
            if (any) begin
              grant     <= pick;
              grant_idx <= pick_idx;
            end else begin
              grant       <= '0;
              grant_idx   <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_idx   <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter for eight requesters, sitting directly upstream of the 8-to-3 encoder stage. It samples an 8-bit request vector and issues a registered one-hot grant that is held until the owner releases it. It also emits the matching 3-bit index and a valid flag. The one-hot `grant` output is guaranteed to have at most one bit set, which is the only legal input class for the downstream encoder.

## Interface
- `N`, 8: number of requesters; fixed at 8 for this revision (power of two required).
- `IDX_W`, 3: index width, log2(`N`).
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  N  request vector; bit i high = requester i wants ownership.
- `release`  input  1  one-cycle pulse from the current owner ending its grant; ignored when `grant_valid`=0.
- `grant`  output  N  registered one-hot grant; all-zero when idle.
- `grant_valid`  output  1  high while a grant is held.
- `grant_idx`  output  IDX_W  binary index of the granted requester; 0 when idle.

## Operation
- Internal state:
  - `ptr` [IDX_W-1:0]: highest-priority position for the next arbitration.
  - FSM state, either IDLE or BUSY.
- Pick function: the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … , `ptr`+7, all mod 8 (wraps 7→0).
- IDLE:
  - If `req`≠0, register the picked grant and go to BUSY.
  - Else stay in IDLE with outputs zero.
- BUSY, `release`=0:
  - Hold `grant`/`grant_idx` unchanged.
  - `req` changes, including the owner dropping its bit, do not revoke the grant.
- BUSY, `release`=1:
  - Set `ptr` ← `grant_idx`+1 mod 8.
  - Run the pick over the current `req` using the new `ptr`. The releasing requester is eligible but has lowest priority.
  - If a requester is picked, register the new grant and stay in BUSY (back-to-back, no idle cycle).
  - If none is picked, clear outputs and go to IDLE.
- Invariants:
  - `grant_valid`=1 ⇔ state BUSY ⇔ `grant`≠0.
  - `grant` == 1<<`grant_idx` whenever valid.
  - `popcount(grant)` ≤ 1 always.
- Reset (asynchronous, any cycle, including mid-grant):
  - `grant`=0, `grant_valid`=0, `grant_idx`=0, `ptr`=0, state IDLE.
  - Takes effect immediately, with no clock edge needed.
  - After `rst` deasserts, the first arbitration uses `ptr`=0.

## Timing
- Latency: `req` stable before rising edge k → `grant`/`grant_idx`/`grant_valid` valid after edge k (1 cycle).
- Release: `release` sampled at edge k → old grant gone after edge k.
  - The next grant, if any, is visible after that same edge k.
  - Each grant is held at least 1 cycle.
- All outputs are flop-driven; there is no combinational path from `req` or `release` to outputs.
- Throughput: one grant per cycle when every owner releases in its first grant cycle.

## Structure
- Shared package `arb_pkg`: `N`, `IDX_W`, and the state enum (IDLE, BUSY).
- One sub-module: `rr_pick`, purely combinational.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `pick`, binary `pick_idx`, `any`.
  - Implementation: rotate right by `ptr`, fixed priority from LSB, rotate back.
- Top level holds the FSM, `ptr`, and the output registers.

## Test plan
- Reset: assert `rst` with `req`=8'hFF → `grant`=0, `grant_valid`=0, `grant_idx`=0.
  - Deassert `rst` → first grant after 1 edge is 8'b00000001, `grant_idx`=0.
- Single requester: `req`=8'b00000100 → after 1 edge `grant`=8'b00000100, `grant_idx`=2.
  - Grant is held for 5 cycles with `release`=0.
  - Drop `req`, pulse `release` → `grant`=0, `grant_valid`=0 next cycle.
- Fairness: `req`=8'hFF, `release` pulsed every cycle.
  - Required `grant_idx` sequence: 0,1,2,…,7,0 with no gap cycles.
- Wrap-around: grant idx 5, then release so `ptr`=6, with `req`=8'b00100001.
  - Next grant is idx 0, not 5.
- Hold against request drop: owner idx 3 deasserts `req[3]` while others request.
  - `grant` stays 8'b00001000 until `release`.
- Async reset mid-grant: `grant`=8'b10000000, `rst` pulsed between clock edges.
  - Outputs go to 0 before the next edge.
  - After reset, `req`=8'b10000001 → grant idx 0.
